// File: rtl/uart_tx_byte_fifo.sv
// Byte FIFO and launch sequencer feeding UART_TX.
// Queues producer bytes and hands them out one launch pulse at a time.
module uart_tx_byte_fifo #(
  parameter int DEPTH        = 16,
  parameter int DATA_W       = 8,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       wr_valid_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  output logic                       wr_ready_o,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       tx_dv_o,
  output logic [DATA_W-1:0]          tx_byte_o,
  input  logic                       tx_active_i,
  input  logic                       tx_done_i,
  output logic                       busy_o,
  output logic                       overflow_o,
  output logic                       timeout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } state_t;

  state_t state, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [TW-1:0]     tmr, tmr_d;
  logic              full, empty;
  logic              push, pop;
  logic              ovf_set, tmo_set;
  logic              dv_d;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign wr_ready_o = !full;
  assign level_o    = count;
  assign busy_o     = (state != IDLE);

  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign push    = wr_valid_i && (!full || pop) && !flush_i;
  assign ovf_set = wr_valid_i && full && !pop && !flush_i;

  always_comb begin
    state_d = state;
    tmr_d   = tmr;
    pop     = 1'b0;
    dv_d    = 1'b0;
    tmo_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !tx_active_i && !flush_i) begin
          pop     = 1'b1;
          dv_d    = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        tmr_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done_i) begin
          state_d = GAP;
        end else if (TIMEOUT_CLKS != 0 &&
                     tmr == TW'(TIMEOUT_CLKS - 1)) begin
          tmo_set = 1'b1;
          state_d = GAP;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      tmr       <= '0;
      tx_dv_o   <= 1'b0;
      tx_byte_o <= '0;
    end else begin
      state   <= state_d;
      tmr     <= tmr_d;
      tx_dv_o <= dv_d;
      if (pop) begin
        tx_byte_o <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set) begin
        overflow_o <= 1'b1;
      end
      if (tmo_set) begin
        timeout_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

endmodule

// File: tb/tb_uart_tx_byte_fifo.sv
// Bench for uart_tx_byte_fifo: launch-order scoreboard plus
// per-scenario latency, overflow, timeout and reset checks.
module tb_uart_tx_byte_fifo;

  localparam int DEPTH    = 16;
  localparam int DATA_W   = 8;
  localparam int LW       = 5;
  localparam int BIT_CLKS = 217;

  logic              clk_i       = 1'b0;
  logic              rst_n_i     = 1'b0;
  logic              wr_valid_i  = 1'b0;
  logic [DATA_W-1:0] wr_data_i   = '0;
  logic              flush_i     = 1'b0;
  logic              tx_active_i = 1'b0;
  logic              tx_done_i   = 1'b0;
  logic              wr_ready_o;
  logic [LW-1:0]     level_o;
  logic              tx_dv_o;
  logic [DATA_W-1:0] tx_byte_o;
  logic              busy_o;
  logic              overflow_o;
  logic              timeout_o;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_dv_cyc = 0;
  int          launches = 0;
  logic [7:0]  sb [$];
  logic [7:0]  exp_b;
  logic        prev_dv = 1'b0;

  uart_tx_byte_fifo #(
    .DEPTH       (DEPTH),
    .DATA_W      (DATA_W),
    .TIMEOUT_CLKS(4096)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .wr_valid_i (wr_valid_i),
    .wr_data_i  (wr_data_i),
    .wr_ready_o (wr_ready_o),
    .flush_i    (flush_i),
    .level_o    (level_o),
    .tx_dv_o    (tx_dv_o),
    .tx_byte_o  (tx_byte_o),
    .tx_active_i(tx_active_i),
    .tx_done_i  (tx_done_i),
    .busy_o     (busy_o),
    .overflow_o (overflow_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Launch monitor: every pulse must be one cycle wide and carry the
  // oldest byte still expected.
  always @(negedge clk_i) begin
    if (rst_n_i && tx_dv_o) begin
      launches++;
      last_dv_cyc = cyc;
      checks++;
      if (prev_dv) begin
        errors++;
        $display("FAIL dv_width: tx_dv_o high 2 cycles, expected 1");
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_launch: got byte %h, expected none",
                 tx_byte_o);
      end else begin
        exp_b = sb.pop_front();
        if (tx_byte_o !== exp_b) begin
          errors++;
          $display("FAIL launch_byte: got %h expected %h",
                   tx_byte_o, exp_b);
        end
      end
    end
    prev_dv = rst_n_i && tx_dv_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b);
    @(negedge clk_i);
    wr_valid_i = 1'b1;
    wr_data_i  = b;
    if (wr_ready_o) sb.push_back(b);
  endtask

  task automatic release_wr();
    @(negedge clk_i);
    wr_valid_i = 1'b0;
  endtask

  task automatic wait_dv(input string tag, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_i);
      if (tx_dv_o) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no tx_dv_o in 200 cycles, expected launch", tag);
    end
  endtask

  task automatic serve(input int n);
    bit seen;
    for (int i = 0; i < n; i++) begin
      wait_dv("serve_launch", seen);
      if (!seen) break;
      @(negedge clk_i);
      tx_done_i = 1'b1;
      @(negedge clk_i);
      tx_done_i = 1'b0;
    end
  endtask

  task automatic uart_model(input int n);
    bit          seen;
    int unsigned exp_cyc;
    exp_cyc = 0;
    for (int i = 0; i < n; i++) begin
      wait_dv("b2b_launch", seen);
      if (!seen) break;
      if (i > 0) begin
        checks++;
        if (cyc !== exp_cyc) begin
          errors++;
          $display("FAIL b2b_spacing: launch at cycle %0d expected %0d",
                   cyc, exp_cyc);
        end
      end
      tx_active_i = 1'b1;
      repeat (10 * BIT_CLKS - 1) @(negedge clk_i);
      tx_done_i   = 1'b1;
      tx_active_i = 1'b0;
      exp_cyc     = cyc + 3;
      @(negedge clk_i);
      tx_done_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    checks++;
    if (tx_dv_o !== 1'b0 || busy_o !== 1'b0 || tx_byte_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_fsm: dv=%b busy=%b byte=%h expected 0 0 00",
               tx_dv_o, busy_o, tx_byte_o);
    end
    rst_n_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (level_o !== 5'd0 || wr_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_fifo: level=%0d ready=%b expected 0 1",
               level_o, wr_ready_o);
    end
    checks++;
    if (overflow_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ovf=%b tmo=%b expected 0 0",
               overflow_o, timeout_o);
    end
  endtask

  task automatic test_single();
    tx_active_i = 1'b0;
    push(8'h61);
    release_wr();
    checks++;
    if (level_o !== 5'd1 || tx_dv_o !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: level=%0d dv=%b expected 1 0",
               level_o, tx_dv_o);
    end
    @(negedge clk_i);
    checks++;
    if (tx_dv_o !== 1'b1 || level_o !== 5'd0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_launch: dv=%b level=%0d busy=%b expected 1 0 1",
               tx_dv_o, level_o, busy_o);
    end
    @(negedge clk_i);
    checks++;
    if (tx_dv_o !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: dv=%b expected 0", tx_dv_o);
    end
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || tx_byte_o !== 8'h61) begin
      errors++;
      $display("FAIL single_done: busy=%b byte=%h expected 0 61",
               busy_o, tx_byte_o);
    end
  endtask

  task automatic test_back_to_back();
    int l0;
    l0 = launches;
    fork
      begin
        push(8'h61);
        push(8'h62);
        push(8'h63);
        release_wr();
      end
      uart_model(3);
    join
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (launches - l0 !== 3 || sb.size() !== 0) begin
      errors++;
      $display("FAIL b2b_count: launches=%0d left=%0d expected 3 0",
               launches - l0, sb.size());
    end
  endtask

  task automatic test_overflow();
    tx_active_i = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    release_wr();
    checks++;
    if (wr_ready_o !== 1'b0 || level_o !== 5'd16 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL full: ready=%b level=%0d ovf=%b expected 0 16 0",
               wr_ready_o, level_o, overflow_o);
    end
    push(8'hEE);
    release_wr();
    checks++;
    if (overflow_o !== 1'b1 || level_o !== 5'd16) begin
      errors++;
      $display("FAIL overflow: ovf=%b level=%0d expected 1 16",
               overflow_o, level_o);
    end
    @(negedge clk_i);
    flush_i    = 1'b1;
    wr_valid_i = 1'b1;
    wr_data_i  = 8'hDD;
    @(negedge clk_i);
    flush_i    = 1'b0;
    wr_valid_i = 1'b0;
    sb.delete();
    checks++;
    if (level_o !== 5'd0 || overflow_o !== 1'b0 || wr_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush: level=%0d ovf=%b ready=%b expected 0 0 1",
               level_o, overflow_o, wr_ready_o);
    end
    flush_i    = 1'b1;
    wr_valid_i = 1'b1;
    wr_data_i  = 8'hCC;
    @(negedge clk_i);
    flush_i    = 1'b0;
    wr_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (level_o !== 5'd0) begin
      errors++;
      $display("FAIL flush_push: level=%0d expected 0", level_o);
    end
  endtask

  task automatic test_full_push_pop();
    tx_active_i = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    release_wr();
    @(negedge clk_i);
    tx_active_i = 1'b0;
    wr_valid_i  = 1'b1;
    wr_data_i   = 8'hA5;
    sb.push_back(8'hA5);
    @(negedge clk_i);
    wr_valid_i  = 1'b0;
    tx_active_i = 1'b1;
    checks++;
    if (level_o !== 5'd16 || tx_dv_o !== 1'b1) begin
      errors++;
      $display("FAIL full_pushpop: level=%0d dv=%b expected 16 1",
               level_o, tx_dv_o);
    end
    @(negedge clk_i);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i   = 1'b0;
    tx_active_i = 1'b0;
    serve(16);
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (sb.size() !== 0 || level_o !== 5'd0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: left=%0d level=%0d ovf=%b expected 0 0 0",
               sb.size(), level_o, overflow_o);
    end
  endtask

  task automatic test_timeout();
    int unsigned c0;
    tx_active_i = 1'b0;
    push(8'h71);
    push(8'h72);
    release_wr();
    #1;
    c0 = last_dv_cyc;
    checks++;
    if (c0 !== cyc) begin
      errors++;
      $display("FAIL tmo_launch: launch at cycle %0d expected %0d", c0, cyc);
    end
    repeat (4096) @(negedge clk_i);
    checks++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early: tmo=%b busy=%b expected 0 1",
               timeout_o, busy_o);
    end
    @(negedge clk_i);
    checks++;
    if (timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL tmo_set: tmo=%b expected 1", timeout_o);
    end
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || tx_dv_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle: busy=%b dv=%b expected 0 0",
               busy_o, tx_dv_o);
    end
    @(negedge clk_i);
    checks++;
    if (tx_dv_o !== 1'b1) begin
      errors++;
      $display("FAIL tmo_next: dv=%b expected 1", tx_dv_o);
    end
    @(negedge clk_i);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    checks++;
    if (timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky: tmo=%b expected 1", timeout_o);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    repeat (3) @(negedge clk_i);
    tx_active_i = 1'b0;
    push(8'h80);
    push(8'h81);
    push(8'h82);
    tx_active_i = 1'b1;
    push(8'h83);
    push(8'h84);
    push(8'h85);
    release_wr();
    checks++;
    if (level_o !== 5'd5 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: level=%0d busy=%b expected 5 1",
               level_o, busy_o);
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (tx_dv_o !== 1'b0 || busy_o !== 1'b0 || tx_byte_o !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst_fsm: dv=%b busy=%b byte=%h expected 0 0 00",
               tx_dv_o, busy_o, tx_byte_o);
    end
    checks++;
    if (level_o !== 5'd0 || wr_ready_o !== 1'b1 ||
        overflow_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_fifo: level=%0d rdy=%b ovf=%b tmo=%b exp 0 1 0 0",
               level_o, wr_ready_o, overflow_o, timeout_o);
    end
    repeat (2) @(negedge clk_i);
    rst_n_i     = 1'b1;
    tx_active_i = 1'b0;
    n0 = launches;
    repeat (20) @(negedge clk_i);
    #1;
    checks++;
    if (launches !== n0) begin
      errors++;
      $display("FAIL mid_no_launch: launches=%0d expected %0d",
               launches, n0);
    end
    push(8'h99);
    release_wr();
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (launches !== n0 + 1 || sb.size() !== 0) begin
      errors++;
      $display("FAIL mid_relaunch: launches=%0d left=%0d expected %0d 0",
               launches, sb.size(), n0 + 1);
    end
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_timeout();
    test_reset_mid();
    repeat (4) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
